// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl
//   Sequencer for a multi-band FIR filter sharing one stereo sample queue.
//   Each accepted codec sample is written into a circular queue. Once the
//   queue holds TAPS samples, every new sample starts a filter pass: the read
//   address walks from the oldest sample to the newest while `sequencing` is
//   held high for SEQ_LEN cycles, followed by a single-cycle `filt_done`.
//   Samples that arrive while a write or pass is in flight are dropped and
//   latch the sticky `ovr` flag.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   smpl_vld    in   one-cycle strobe: new stereo sample
//   lft_smpl    in   16-bit signed left sample
//   rght_smpl   in   16-bit signed right sample
//   wr_en       out  queue write strobe
//   wr_addr     out  queue write address (AW bits)
//   lft_wdata   out  queue write data, left
//   rght_wdata  out  queue write data, right
//   rd_addr     out  queue read address to the filter bands (AW bits)
//   sequencing  out  run strobe to the filter bands
//   filt_done   out  one-cycle pulse, band outputs valid
//   ovr         out  sticky sample-overrun flag
module fir_seq_ctrl #(
    parameter int TAPS    = 1021,
    parameter int SEQ_LEN = 1022,
    parameter int AW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          smpl_vld,
    input  logic [15:0]   lft_smpl,
    input  logic [15:0]   rght_smpl,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   lft_wdata,
    output logic [15:0]   rght_wdata,
    output logic [AW-1:0] rd_addr,
    output logic          sequencing,
    output logic          filt_done,
    output logic          ovr
);

    localparam int CW = $clog2(SEQ_LEN + 1);
    localparam int FW = $clog2(TAPS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(SEQ_LEN - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(TAPS);
    // Distance from the newest sample back to the oldest one, modulo the
    // queue depth; the subtraction below wraps naturally in AW bits.
    localparam logic [AW-1:0] BACK_OFS  = AW'(TAPS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] SEQ   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [AW-1:0] wptr;
    logic [AW-1:0] wptr_nx;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_nx;
    logic [FW-1:0] fill_inc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [AW-1:0] rd_addr_nx;
    logic [AW-1:0] wr_addr_nx;
    logic [15:0]   lft_wdata_nx;
    logic [15:0]   rght_wdata_nx;
    logic          wr_en_nx;
    logic          sequencing_nx;
    logic          filt_done_nx;
    logic          ovr_nx;

    always_comb begin
        state_nx      = state;
        wptr_nx       = wptr;
        fill_nx       = fill;
        cnt_nx        = cnt;
        rd_addr_nx    = rd_addr;
        wr_addr_nx    = wr_addr;
        lft_wdata_nx  = lft_wdata;
        rght_wdata_nx = rght_wdata;
        wr_en_nx      = 1'b0;
        sequencing_nx = sequencing;
        filt_done_nx  = 1'b0;
        ovr_nx        = ovr;

        // Fill count saturates once the queue holds a full tap window.
        fill_inc = (fill == FILL_FULL) ? fill : fill + 1'b1;

        case (state)
            IDLE: begin
                if (smpl_vld) begin
                    state_nx      = WRITE;
                    wr_en_nx      = 1'b1;
                    wr_addr_nx    = wptr;
                    lft_wdata_nx  = lft_smpl;
                    rght_wdata_nx = rght_smpl;
                end
            end

            WRITE: begin
                wptr_nx = wptr + 1'b1;
                fill_nx = fill_inc;
                if (fill_inc == FILL_FULL) begin
                    // wr_addr still holds the address just written (newest).
                    state_nx      = SEQ;
                    rd_addr_nx    = wr_addr - BACK_OFS;
                    cnt_nx        = '0;
                    sequencing_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end

            SEQ: begin
                if (cnt == CNT_LAST) begin
                    state_nx      = DONE;
                    sequencing_nx = 1'b0;
                    filt_done_nx  = 1'b1;
                end else begin
                    cnt_nx     = cnt + 1'b1;
                    rd_addr_nx = rd_addr + 1'b1;
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // Any sample outside IDLE cannot be queued; it is lost.
        if (smpl_vld && (state != IDLE)) begin
            ovr_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wptr       <= '0;
            fill       <= '0;
            cnt        <= '0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            lft_wdata  <= '0;
            rght_wdata <= '0;
            wr_en      <= 1'b0;
            sequencing <= 1'b0;
            filt_done  <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            state      <= state_nx;
            wptr       <= wptr_nx;
            fill       <= fill_nx;
            cnt        <= cnt_nx;
            rd_addr    <= rd_addr_nx;
            wr_addr    <= wr_addr_nx;
            lft_wdata  <= lft_wdata_nx;
            rght_wdata <= rght_wdata_nx;
            wr_en      <= wr_en_nx;
            sequencing <= sequencing_nx;
            filt_done  <= filt_done_nx;
            ovr        <= ovr_nx;
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl
//   Bench for fir_seq_ctrl. Two instances: one with default parameters for
//   the long directed scenarios, one tiny instance for a hand-derived vector
//   table and randomized traffic. A cycle-schedule reference model predicts
//   every output of both instances on every cycle.
module tb_fir_seq_ctrl;

    localparam int B_TAPS = 1021;
    localparam int B_SEQ  = 1022;
    localparam int B_AW   = 10;
    localparam int S_TAPS = 3;
    localparam int S_SEQ  = 5;
    localparam int S_AW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic            a_rst, a_vld;
    logic [15:0]     a_lft, a_rgt;
    logic            a_wr_en;
    logic [B_AW-1:0] a_wr_addr;
    logic [15:0]     a_lw, a_rw;
    logic [B_AW-1:0] a_rd;
    logic            a_seq, a_done, a_ovr;

    // small instance
    logic            b_rst, b_vld;
    logic [15:0]     b_lft, b_rgt;
    logic            b_wr_en;
    logic [S_AW-1:0] b_wr_addr;
    logic [15:0]     b_lw, b_rw;
    logic [S_AW-1:0] b_rd;
    logic            b_seq, b_done, b_ovr;

    fir_seq_ctrl dut_big (
        .clk(clk), .rst(a_rst), .smpl_vld(a_vld),
        .lft_smpl(a_lft), .rght_smpl(a_rgt),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .lft_wdata(a_lw), .rght_wdata(a_rw),
        .rd_addr(a_rd), .sequencing(a_seq),
        .filt_done(a_done), .ovr(a_ovr)
    );

    fir_seq_ctrl #(.TAPS(S_TAPS), .SEQ_LEN(S_SEQ), .AW(S_AW)) dut_small (
        .clk(clk), .rst(b_rst), .smpl_vld(b_vld),
        .lft_smpl(b_lft), .rght_smpl(b_rgt),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .lft_wdata(b_lw), .rght_wdata(b_rw),
        .rd_addr(b_rd), .sequencing(b_seq),
        .filt_done(b_done), .ovr(b_ovr)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int seq_hi_cnt = 0;
    int done_cnt   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: the accepted-sample schedule expressed as absolute cycle
    // numbers. Edge e ends cycle e; cycle e+1 follows it.
    int          m_taps[2], m_seq[2], m_aw[2];
    int          m_free[2];      // first edge at which a sample is accepted
    bit          m_pass[2];      // a pass has been scheduled since reset
    int          m_s[2];         // first sequencing cycle of latest pass
    int          m_start[2];     // first read address of latest pass
    int          m_rdprev[2];    // read address held before the latest pass
    int          m_wptr[2], m_fill[2], m_wrc[2], m_wa[2];
    bit          m_ovr[2];
    logic [15:0] m_lw[2], m_rw[2];

    function automatic int exp_rd(int i, int c);
        int off;
        if (m_pass[i] && c >= m_s[i]) begin
            off = c - m_s[i];
            if (off > m_seq[i] - 1) off = m_seq[i] - 1;
            return (m_start[i] + off) % (1 << m_aw[i]);
        end
        return m_rdprev[i];
    endfunction

    task automatic model_edge(int i, bit r, bit v, logic [15:0] l, logic [15:0] g);
        int e;
        int depth;
        e = cyc;
        depth = 1 << m_aw[i];
        if (r) begin
            m_free[i] = e + 1; m_pass[i] = 0; m_rdprev[i] = 0;
            m_wptr[i] = 0; m_fill[i] = 0; m_ovr[i] = 0; m_wrc[i] = -1;
            m_wa[i] = 0; m_lw[i] = '0; m_rw[i] = '0;
        end else if (v) begin
            if (e >= m_free[i]) begin
                m_wrc[i] = e + 1;
                m_wa[i]  = m_wptr[i];
                m_lw[i]  = l;
                m_rw[i]  = g;
                m_wptr[i] = (m_wptr[i] + 1) % depth;
                if (m_fill[i] < m_taps[i]) m_fill[i]++;
                if (m_fill[i] == m_taps[i]) begin
                    m_rdprev[i] = exp_rd(i, e + 1);
                    m_pass[i]   = 1;
                    m_s[i]      = e + 2;
                    m_start[i]  = ((m_wa[i] - (m_taps[i] - 1)) % depth + depth) % depth;
                    m_free[i]   = e + 3 + m_seq[i];
                end else begin
                    m_free[i] = e + 2;
                end
            end else begin
                m_ovr[i] = 1;
            end
        end
    endtask

    function automatic logic [63:0] exp_vec(int i, int c);
        bit we, sq, dn;
        we = (c == m_wrc[i]);
        sq = m_pass[i] && (c >= m_s[i]) && (c <= m_s[i] + m_seq[i] - 1);
        dn = m_pass[i] && (c == m_s[i] + m_seq[i]);
        return {8'b0, we, 10'(m_wa[i]), m_lw[i], m_rw[i], 10'(exp_rd(i, c)), sq, dn, m_ovr[i]};
    endfunction

    function automatic logic [63:0] act_big();
        return {8'b0, a_wr_en, a_wr_addr, a_lw, a_rw, a_rd, a_seq, a_done, a_ovr};
    endfunction

    function automatic logic [63:0] act_small();
        return {8'b0, b_wr_en, 8'b0, b_wr_addr, b_lw, b_rw, 8'b0, b_rd, b_seq, b_done, b_ovr};
    endfunction

    // One clock: model consumes the inputs of the edge, DUTs clock, then both
    // instances are compared against the model away from the active edge.
    task automatic tick();
        model_edge(0, a_rst, a_vld, a_lft, a_rgt);
        model_edge(1, b_rst, b_vld, b_lft, b_rgt);
        cyc++;
        @(posedge clk);
        @(negedge clk);
        chk("model_big", act_big(), exp_vec(0, cyc));
        chk("model_small", act_small(), exp_vec(1, cyc));
        if (a_seq) seq_hi_cnt++;
        if (a_done) done_cnt++;
    endtask

    task automatic big_sample(logic [15:0] l);
        a_vld = 1'b1; a_lft = l; a_rgt = ~l;
        tick();
        a_vld = 1'b0;
    endtask

    // Tick until filt_done is seen, then into the following IDLE cycle.
    task automatic wait_done(string name);
        int n;
        n = 0;
        while (!a_done && n < 1200) begin
            tick();
            n++;
        end
        n_checks++;
        if (!a_done) begin
            n_err++;
            $display("FAIL %s: filt_done not seen within %0d cycles", name, n);
        end
        tick();
    endtask

    // ---------------- vector table (small instance) ----------------
    typedef struct {
        bit          rst, vld;
        logic [15:0] l, r;
        bit          we;
        int          wa;
        logic [15:0] lw, rw;
        int          rd;
        bit          sq, dn, ov;
    } vec_t;

    vec_t tbl[19];

    task automatic set_row(int i, bit rs, bit v, logic [15:0] l, logic [15:0] r,
                           bit we, int wa, logic [15:0] lw, logic [15:0] rw,
                           int rd, bit sq, bit dn, bit ov);
        tbl[i] = '{rs, v, l, r, we, wa, lw, rw, rd, sq, dn, ov};
    endtask

    initial begin
        int start, rd_bad, seq_bad, gap, done_at;
        logic [15:0] wl[5];
        int          wexp[5];

        m_taps[0] = B_TAPS; m_seq[0] = B_SEQ; m_aw[0] = B_AW;
        m_taps[1] = S_TAPS; m_seq[1] = S_SEQ; m_aw[1] = S_AW;
        for (int i = 0; i < 2; i++) begin
            m_free[i] = 0; m_pass[i] = 0; m_rdprev[i] = 0; m_wptr[i] = 0;
            m_fill[i] = 0; m_ovr[i] = 0; m_wrc[i] = -1; m_wa[i] = 0;
            m_lw[i] = '0; m_rw[i] = '0; m_s[i] = 0; m_start[i] = 0;
        end
        a_rst = 1'b1; a_vld = 1'b0; a_lft = '0; a_rgt = '0;
        b_rst = 1'b1; b_vld = 1'b0; b_lft = '0; b_rgt = '0;

        //        rst vld  lft      rght    | we wa lw       rw       rd sq dn ov
        set_row( 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        set_row( 1, 0, 1, 16'h0011, 16'h0021, 1, 0, 16'h0011, 16'h0021, 0, 0, 0, 0);
        set_row( 2, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0011, 16'h0021, 0, 0, 0, 0);
        set_row( 3, 0, 1, 16'h0012, 16'h0022, 1, 1, 16'h0012, 16'h0022, 0, 0, 0, 0);
        set_row( 4, 0, 1, 16'h0013, 16'h0023, 0, 1, 16'h0012, 16'h0022, 0, 0, 0, 1);
        set_row( 5, 0, 1, 16'h0014, 16'h0024, 1, 2, 16'h0014, 16'h0024, 0, 0, 0, 1);
        set_row( 6, 0, 0, 16'h0000, 16'h0000, 0, 2, 16'h0014, 16'h0024, 0, 1, 0, 1);
        set_row( 7, 0, 0, 16'h0000, 16'h0000, 0, 2, 16'h0014, 16'h0024, 1, 1, 0, 1);
        set_row( 8, 0, 1, 16'h0015, 16'h0025, 0, 2, 16'h0014, 16'h0024, 2, 1, 0, 1);
        set_row( 9, 0, 0, 16'h0000, 16'h0000, 0, 2, 16'h0014, 16'h0024, 3, 1, 0, 1);
        set_row(10, 0, 0, 16'h0000, 16'h0000, 0, 2, 16'h0014, 16'h0024, 0, 1, 0, 1);
        set_row(11, 0, 0, 16'h0000, 16'h0000, 0, 2, 16'h0014, 16'h0024, 0, 0, 1, 1);
        set_row(12, 0, 1, 16'h0016, 16'h0026, 0, 2, 16'h0014, 16'h0024, 0, 0, 0, 1);
        set_row(13, 0, 1, 16'h0017, 16'h0027, 1, 3, 16'h0017, 16'h0027, 0, 0, 0, 1);
        set_row(14, 0, 0, 16'h0000, 16'h0000, 0, 3, 16'h0017, 16'h0027, 1, 1, 0, 1);
        set_row(15, 0, 0, 16'h0000, 16'h0000, 0, 3, 16'h0017, 16'h0027, 2, 1, 0, 1);
        set_row(16, 1, 1, 16'h0019, 16'h0029, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        set_row(17, 0, 1, 16'h0018, 16'h0028, 1, 0, 16'h0018, 16'h0028, 0, 0, 0, 0);
        set_row(18, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0018, 16'h0028, 0, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            b_rst = tbl[i].rst; b_vld = tbl[i].vld;
            b_lft = tbl[i].l;   b_rgt = tbl[i].r;
            tick();
            chk($sformatf("tbl_row%0d", i), act_small(),
                {8'b0, tbl[i].we, 8'b0, 2'(tbl[i].wa), tbl[i].lw, tbl[i].rw,
                 8'b0, 2'(tbl[i].rd), tbl[i].sq, tbl[i].dn, tbl[i].ov});
        end

        // randomized traffic on the small instance, checked by the model
        for (int i = 0; i < 1500; i++) begin
            b_rst = ($urandom_range(0, 99) == 0);
            b_vld = ($urandom_range(0, 2) == 0);
            b_lft = 16'($urandom);
            b_rgt = 16'($urandom);
            tick();
        end
        b_rst = 1'b0; b_vld = 1'b0;

        // ---------------- default instance: directed ----------------
        a_rst = 1'b1;
        tick();
        tick();
        a_rst = 1'b0;
        chk("rst_vec", act_big(), 64'd0);

        // priming: 1020 samples, no pass
        seq_hi_cnt = 0;
        for (int p = 0; p < B_TAPS - 1; p++) begin
            big_sample(16'(p));
            if (p == B_TAPS - 2) chk("prime_last_addr", a_wr_addr, 1019);
            repeat (3) tick();
        end
        chk("prime_no_seq", seq_hi_cnt, 0);

        // first pass
        big_sample(16'h1234);
        chk("p1_wr_en", a_wr_en, 1);
        chk("p1_wr_addr", a_wr_addr, 1020);
        chk("p1_lft_wdata", a_lw, 16'h1234);
        seq_hi_cnt = 0; done_cnt = 0; done_at = -1; gap = 0;
        for (int j = 2; j <= 1025; j++) begin
            tick();
            if (j == 2) begin
                chk("p1_rd_first", a_rd, 0);
                chk("p1_seq_first", a_seq, 1);
            end
            if (j == 1022) chk("p1_rd_newest", a_rd, 1020);
            if (a_done && done_at < 0) done_at = j;
            if (j >= 1024 && !a_seq) gap++;
        end
        chk("p1_seq_len", seq_hi_cnt, B_SEQ);
        chk("p1_done_at", done_at, 1024);
        chk("p1_done_cnt", done_cnt, 1);

        // back-to-back sample in the cycle after filt_done
        big_sample(16'h2222);
        chk("b2b_wr_en", a_wr_en, 1);
        chk("b2b_wr_addr", a_wr_addr, 1021);
        if (!a_seq) gap++;
        tick();
        chk("b2b_seq", a_seq, 1);
        chk("b2b_gap", gap, 3);

        // overrun during SEQ
        repeat (100) tick();
        big_sample(16'hdead);
        chk("ovr_no_wr", a_wr_en, 0);
        chk("ovr_set", a_ovr, 1);
        wait_done("ovr_pass_done");
        chk("ovr_hold", a_ovr, 1);

        // walk wptr through the wrap point up to address 2
        wl   = '{16'h1022, 16'h1023, 16'h0000, 16'h0001, 16'h0002};
        wexp = '{1022, 1023, 0, 1, 2};
        for (int w = 0; w < 5; w++) begin
            big_sample(wl[w]);
            chk($sformatf("walk_addr%0d", w), a_wr_addr, wexp[w]);
            wait_done($sformatf("walk_done%0d", w));
        end

        // wrap pass: newest sample at address 3
        big_sample(16'h0003);
        chk("wrap_wr_addr", a_wr_addr, 3);
        start = ((3 - (B_TAPS - 1)) % 1024 + 1024) % 1024;
        rd_bad = 0; seq_bad = 0;
        for (int i = 0; i < B_SEQ; i++) begin
            tick();
            if (a_rd != 10'((start + i) % 1024)) rd_bad++;
            if (!a_seq) seq_bad++;
            if (i == 0)    chk("wrap_rd_start", a_rd, 7);
            if (i == 1016) chk("wrap_rd_top", a_rd, 1023);
            if (i == 1017) chk("wrap_rd_zero", a_rd, 0);
            if (i == B_TAPS - 1) chk("wrap_rd_newest", a_rd, 3);
        end
        chk("wrap_rd_walk", rd_bad, 0);
        chk("wrap_seq_held", seq_bad, 0);
        tick();
        chk("wrap_done", a_done, 1);
        chk("wrap_rd_hold", a_rd, 10'((start + B_SEQ - 1) % 1024));
        tick();

        // reset in the 500th SEQ cycle
        big_sample(16'h0004);
        tick();
        repeat (499) tick();
        chk("mid_seq_high", a_seq, 1);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("mid_rst_vec", act_big(), 64'd0);
        done_cnt = 0;
        repeat (1100) tick();
        chk("mid_no_done", done_cnt, 0);

        // refill after reset
        seq_hi_cnt = 0;
        for (int p = 0; p < B_TAPS - 1; p++) begin
            big_sample(16'(p + 7));
            repeat (3) tick();
        end
        chk("refill_no_seq", seq_hi_cnt, 0);
        chk("refill_last_addr", a_wr_addr, 1019);
        big_sample(16'h5555);
        tick();
        chk("refill_seq", a_seq, 1);
        chk("refill_rd", a_rd, 0);
        wait_done("refill_done");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
